// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the ram_2w4r controllers.
package ram_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Bits needed to index n items (n >= 2).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v != 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/ram_2w4r_wr_ctrl_if.sv
// Requester-side and RAM write-port bundle of the ram_2w4r write controller.
interface ram_2w4r_wr_ctrl_if #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned RAM_ADDR_WIDTH = 6,
  parameter int unsigned RAM_DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]                req_val;
  logic [NUM_REQ*RAM_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*RAM_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_rdy;
  logic                              init_done;
  logic                              w0_val;
  logic [RAM_ADDR_WIDTH-1:0]         w0_addr;
  logic [RAM_DATA_WIDTH-1:0]         w0_data;
  logic                              w1_val;
  logic [RAM_ADDR_WIDTH-1:0]         w1_addr;
  logic [RAM_DATA_WIDTH-1:0]         w1_data;

  modport master (
    output req_val, req_addr, req_data,
    input  req_rdy, init_done,
    input  w0_val, w0_addr, w0_data, w1_val, w1_addr, w1_data
  );

  modport slave (
    input  req_val, req_addr, req_data,
    output req_rdy, init_done,
    output w0_val, w0_addr, w0_data, w1_val, w1_addr, w1_data
  );

endinterface

// File: rtl/rr_pick2.sv
// Round-robin picker granting up to two requesters per cycle; the second
// grant must target an address different from the first.
module rr_pick2
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned PTR_WIDTH  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            req_val,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [PTR_WIDTH-1:0]          ptr,
  output logic [NUM_REQ-1:0]            gnt0,
  output logic [NUM_REQ-1:0]            gnt1,
  output logic [PTR_WIDTH-1:0]          sel0,
  output logic [PTR_WIDTH-1:0]          sel1,
  output logic [PTR_WIDTH-1:0]          next_ptr
);

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic                  found0;
  logic                  found1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [PTR_WIDTH-1:0]  idx;

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Scan from ptr; port 0 takes the first requester, port 1 the next one
  // whose address differs from port 0's (colliding requesters stay pending).
  always_comb begin
    gnt0     = '0;
    gnt1     = '0;
    sel0     = '0;
    sel1     = '0;
    found0   = 1'b0;
    found1   = 1'b0;
    addr0    = '0;
    idx      = '0;
    next_ptr = ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_WIDTH'((32'(ptr) + k) % NUM_REQ);
      if (req_val[idx]) begin
        if (!found0) begin
          gnt0[idx] = 1'b1;
          sel0      = idx;
          found0    = 1'b1;
          addr0     = addr_a[idx];
          next_ptr  = PTR_WIDTH'((32'(idx) + 32'd1) % NUM_REQ);
        end else if (!found1 && (addr_a[idx] != addr0)) begin
          gnt1[idx] = 1'b1;
          sel1      = idx;
          found1    = 1'b1;
          next_ptr  = PTR_WIDTH'((32'(idx) + 32'd1) % NUM_REQ);
        end
      end
    end
  end

endmodule

// File: rtl/ram_2w4r_wr_ctrl.sv
// Write-side controller for ram_2w4r: sweeps all entries to INIT_VAL after
// reset, then arbitrates requesters onto the two RAM write ports.
module ram_2w4r_wr_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned                NUM_REQ        = 4,
  parameter int unsigned                RAM_DEPTH      = 64,
  parameter int unsigned                RAM_ADDR_WIDTH = 6,
  parameter int unsigned                RAM_DATA_WIDTH = 32,
  parameter logic [RAM_DATA_WIDTH-1:0]  INIT_VAL       = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_2w4r_wr_ctrl_if.slave    bus
);

  localparam int unsigned PTR_WIDTH = clog2(NUM_REQ);
  localparam int unsigned CNT_WIDTH = RAM_ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(RAM_DEPTH);

  state_t                    state;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [CNT_WIDTH-1:0]      cnt_p1;
  logic [CNT_WIDTH-1:0]      cnt_p2;
  logic [PTR_WIDTH-1:0]      ptr;
  logic [PTR_WIDTH-1:0]      next_ptr;
  logic [PTR_WIDTH-1:0]      sel0;
  logic [PTR_WIDTH-1:0]      sel1;
  logic [NUM_REQ-1:0]        gnt0;
  logic [NUM_REQ-1:0]        gnt1;
  logic                      any0;
  logic                      any1;
  logic [RAM_ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [RAM_DATA_WIDTH-1:0] data_a [NUM_REQ];

  for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
    assign addr_a[i] = bus.req_addr[i*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
    assign data_a[i] = bus.req_data[i*RAM_DATA_WIDTH +: RAM_DATA_WIDTH];
  end

  rr_pick2 #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (RAM_ADDR_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_pick (
    .req_val  (bus.req_val),
    .req_addr (bus.req_addr),
    .ptr      (ptr),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .sel0     (sel0),
    .sel1     (sel1),
    .next_ptr (next_ptr)
  );

  assign any0        = |gnt0;
  assign any1        = |gnt1;
  assign cnt_p1      = cnt + CNT_WIDTH'(1);
  assign cnt_p2      = cnt + CNT_WIDTH'(2);
  assign bus.req_rdy = (state == ST_RUN) ? (gnt0 | gnt1) : '0;

  // Sweep FSM plus registered RAM write ports; counter is one bit wider than
  // the address so odd depths finish without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      cnt           <= '0;
      ptr           <= '0;
      bus.init_done <= 1'b0;
      bus.w0_val    <= 1'b0;
      bus.w0_addr   <= '0;
      bus.w0_data   <= '0;
      bus.w1_val    <= 1'b0;
      bus.w1_addr   <= '0;
      bus.w1_data   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          bus.w0_val  <= 1'b1;
          bus.w0_addr <= cnt[RAM_ADDR_WIDTH-1:0];
          bus.w0_data <= INIT_VAL;
          bus.w1_val  <= (cnt_p1 < DEPTH);
          bus.w1_addr <= cnt_p1[RAM_ADDR_WIDTH-1:0];
          bus.w1_data <= INIT_VAL;
          cnt         <= cnt_p2;
          if (cnt_p2 >= DEPTH) begin
            state         <= ST_RUN;
            bus.init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          bus.w0_val <= any0;
          bus.w1_val <= any1;
          if (any0) begin
            bus.w0_addr <= addr_a[sel0];
            bus.w0_data <= data_a[sel0];
            ptr         <= next_ptr;
          end
          if (any1) begin
            bus.w1_addr <= addr_a[sel1];
            bus.w1_data <= data_a[sel1];
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_2w4r_wr_ctrl.sv
// Bench for ram_2w4r_wr_ctrl: sweep checks on depths 8 and 5, a vector table,
// random traffic against a queue-based arbitration model, and async resets.
module tb_ram_2w4r_wr_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] IV8 = 32'hA5A5_0F0F;
  localparam logic [DW-1:0] IV5 = 32'h5A5A_1234;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_2w4r_wr_ctrl_if #(.NUM_REQ(N), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) if8 ();
  ram_2w4r_wr_ctrl_if #(.NUM_REQ(N), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) if5 ();

  ram_2w4r_wr_ctrl #(
    .NUM_REQ(N), .RAM_DEPTH(8), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .INIT_VAL(IV8)
  ) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  ram_2w4r_wr_ctrl #(
    .NUM_REQ(N), .RAM_DEPTH(5), .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .INIT_VAL(IV5)
  ) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

  typedef struct {
    logic [N-1:0]    v;
    logic [N*AW-1:0] a;
    int              g0;
    int              g1;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int pm;
  logic [N-1:0]  rv;
  logic [AW-1:0] ra [N];
  logic [DW-1:0] rd [N];
  logic [AW-1:0] e0a, e1a;
  logic [DW-1:0] e0d, e1d;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    if8.req_val = rv;
    for (int i = 0; i < int'(N); i++) begin
      if8.req_addr[i*AW +: AW] = ra[i];
      if8.req_data[i*DW +: DW] = rd[i];
    end
  endtask

  // Reference arbitration: requesters in scan order from p, first to port 0,
  // next one with a different address to port 1.
  function automatic void pick(input logic [N-1:0] v, input logic [AW-1:0] a [N], input int p,
                               output int g0, output int g1, output int np);
    int q[$];
    for (int k = 0; k < int'(N); k++)
      if (v[(p + k) % N]) q.push_back((p + k) % N);
    g0 = -1;
    g1 = -1;
    np = p;
    if (q.size() > 0) begin
      g0 = q[0];
      np = (g0 + 1) % N;
      for (int j = 1; j < q.size(); j++) begin
        if (a[q[j]] != a[g0]) begin
          g1 = q[j];
          np = (g1 + 1) % N;
          break;
        end
      end
    end
  endfunction

  // One RUN cycle on the depth-8 DUT with given expected grants.
  task automatic step(input string tag, input int g0, input int g1);
    logic [N-1:0] er;
    drive();
    er = '0;
    if (g0 >= 0) er[2'(g0)] = 1'b1;
    if (g1 >= 0) er[2'(g1)] = 1'b1;
    #1;
    chk({tag, " rdy"}, 64'(if8.req_rdy), 64'(er));
    @(posedge clk);
    #1;
    if (g0 >= 0) begin e0a = ra[2'(g0)]; e0d = rd[2'(g0)]; end
    if (g1 >= 0) begin e1a = ra[2'(g1)]; e1d = rd[2'(g1)]; end
    chk({tag, " w0"}, {if8.w0_val, if8.w0_addr, if8.w0_data}, {(g0 >= 0), e0a, e0d});
    chk({tag, " w1"}, {if8.w1_val, if8.w1_addr, if8.w1_data}, {(g1 >= 0), e1a, e1d});
    if (if8.w0_val && if8.w1_val)
      chk({tag, " same addr"}, 64'(if8.w0_addr == if8.w1_addr), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " d8 ctl"}, {if8.w0_val, if8.w1_val, if8.init_done, if8.req_rdy, if8.w0_addr, if8.w1_addr}, 64'(0));
    chk({tag, " d8 data"}, {if8.w0_data, if8.w1_data}, 64'(0));
    chk({tag, " d5 ctl"}, {if5.w0_val, if5.w1_val, if5.init_done, if5.req_rdy, if5.w0_addr, if5.w1_addr}, 64'(0));
    chk({tag, " d5 data"}, {if5.w0_data, if5.w1_data}, 64'(0));
  endtask

  // n sweep cycles from address 0; depth-5 DUT checked over its 3 cycles.
  task automatic sweep(input int n, input bit with5);
    for (int c = 0; c < n; c++) begin
      chk("sweep rdy8", 64'(if8.req_rdy), 64'(0));
      chk("sweep done8 pre", 64'(if8.init_done), 64'(0));
      if (with5 && c < 3) begin
        chk("sweep rdy5", 64'(if5.req_rdy), 64'(0));
        chk("sweep done5 pre", 64'(if5.init_done), 64'(0));
      end
      @(posedge clk);
      #1;
      chk("sweep w0 d8", {if8.w0_val, if8.w0_addr, if8.w0_data}, {1'b1, 6'(2*c), IV8});
      chk("sweep w1 d8", {if8.w1_val, if8.w1_addr, if8.w1_data}, {1'b1, 6'(2*c+1), IV8});
      chk("sweep done8", 64'(if8.init_done), 64'(c == 3));
      if (with5 && c < 3) begin
        chk("sweep w0 d5", {if5.w0_val, if5.w0_addr, if5.w0_data}, {1'b1, 6'(2*c), IV5});
        chk("sweep w1 d5", {if5.w1_val, if5.w1_addr, if5.w1_data}, {(2*c+1 < 5), 6'(2*c+1), IV5});
        chk("sweep done5", 64'(if5.init_done), 64'(c == 2));
      end
    end
  endtask

  initial begin
    int g0, g1, np;
    tbl[0] = '{4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 0, 1};
    tbl[1] = '{4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 2, 3};
    tbl[2] = '{4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 0, 1};
    tbl[3] = '{4'b1000, {6'd13, 6'd12, 6'd11, 6'd10}, 3, -1};
    tbl[4] = '{4'b0111, {6'd0,  6'd9,  6'd5,  6'd5 }, 0, 2};
    tbl[5] = '{4'b0010, {6'd0,  6'd9,  6'd5,  6'd5 }, 1, -1};
    tbl[6] = '{4'b1000, {6'd13, 6'd12, 6'd11, 6'd10}, 3, -1};
    tbl[7] = '{4'b1000, {6'd13, 6'd12, 6'd11, 6'd10}, 3, -1};
    tbl[8] = '{4'b0000, {6'd13, 6'd12, 6'd11, 6'd10}, -1, -1};
    tbl[9] = '{4'b1111, {6'd7,  6'd7,  6'd7,  6'd7 }, 0, -1};

    rv = '1;
    for (int i = 0; i < int'(N); i++) begin
      ra[i] = AW'(i + 20);
      rd[i] = 32'hC0DE_0000 + 32'(i);
    end
    drive();
    if5.req_val  = '1;
    if5.req_addr = '0;
    if5.req_data = '0;
    e0a = '0; e1a = '0; e0d = '0; e1d = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    sweep(4, 1'b1);

    for (int e = 0; e < 10; e++) begin
      rv = tbl[e].v;
      for (int i = 0; i < int'(N); i++) begin
        ra[i] = tbl[e].a[i*AW +: AW];
        rd[i] = {8'(e), 8'(i), 16'hBEEF};
      end
      step($sformatf("vec%0d", e), tbl[e].g0, tbl[e].g1);
    end

    pm = 1;
    for (int n = 0; n < 300; n++) begin
      rv = N'($urandom);
      for (int i = 0; i < int'(N); i++) begin
        ra[i] = AW'($urandom_range(0, 3));
        rd[i] = $urandom;
      end
      pick(rv, ra, pm, g0, g1, np);
      step("rand", g0, g1);
      pm = np;
    end

    // Asynchronous reset in RUN: outputs must clear before any clock edge.
    rv = '1;
    drive();
    #2 rst_n = 1'b0;
    #1 chk_zero("run reset async");
    @(posedge clk);
    #1 chk_zero("run reset held");
    @(negedge clk) rst_n = 1'b1;
    sweep(2, 1'b0);

    // Mid-sweep reset with the counter at 4.
    #1 rst_n = 1'b0;
    #1 chk_zero("sweep reset async");
    @(posedge clk);
    #1 chk_zero("sweep reset held");
    @(negedge clk) rst_n = 1'b1;
    sweep(4, 1'b1);

    rv = '1;
    for (int i = 0; i < int'(N); i++) begin
      ra[i] = AW'(i + 10);
      rd[i] = 32'hFACE_0000 + 32'(i);
    end
    step("ptr after reset", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
